fp_stage_fifo: RTL and testbench
================================

# fp_stage_fifo

Parametrised elastic pipeline stage for the floating-point MAC datapath. It replaces the fixed, always-loading inter-stage registers between adder and multiplier stages with a DEPTH-entry buffer that carries the mantissa, exponent and sign/flag fields of one operation per entry. A valid/ready handshake lets downstream stages stall without losing data, and a synchronous flush discards in-flight operations. Successive stages in the adder pipeline are chained through instances of this block.

## Interface
Parameters:
- MANT_W, 25, mantissa field width
- EXP_W, 8, exponent field width
- FLAG_W, 4, sign/status flag bits (sign, result sign, normalise flags) carried unmodified
- DEPTH, 2, number of entries; legal range 2..16
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived; not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all entries
- in_valid  in  1  upstream holds a valid operation
- in_ready  out  1  buffer can accept this cycle
- in_mant  in  MANT_W  mantissa in
- in_exp  in  EXP_W  exponent in
- in_flags  in  FLAG_W  flags in
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head this cycle
- out_mant  out  MANT_W  head mantissa
- out_exp  out  EXP_W  head exponent
- out_flags  out  FLAG_W  head flags
- count  out  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH entries of MANT_W+EXP_W+FLAG_W bits, write pointer wr_ptr, read pointer rd_ptr, occupancy count; pointers wrap from DEPTH-1 to 0 (DEPTH need not be a power of two).
- Push = in_valid && in_ready; writes payload at wr_ptr, wr_ptr advances.
- Pop = out_valid && out_ready; rd_ptr advances.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- in_ready = (count != DEPTH); decoded from registered state only, never combinationally from out_ready.
- out_valid = (count != 0); out_* = storage[rd_ptr], driven from registers/mux of registers, no combinational path from in_* to out_*.
- Payload passes bit-exact; no arithmetic on any field.
- Full: in_ready=0; a pop in that cycle does not enable a same-cycle push; in_ready rises the cycle after.
- Empty: out_valid=0; out_* hold storage[rd_ptr] (stale) and are don't-care for the bench except after reset.
- flush: next edge sets count=0, wr_ptr=rd_ptr=0; push and pop in the flush cycle are ignored; storage contents are not cleared. flush has priority over push/pop.
- Reset (rst_n low, any time incl. mid-transfer): immediately count=0, pointers=0, all storage=0, so out_valid=0, in_ready=1, out_mant/out_exp/out_flags=0. Operations in flight are lost.

## Timing
- Latency: an entry pushed at edge k into an empty buffer is presented with out_valid=1 after edge k (visible in cycle k+1).
- Throughput: one push and one pop per cycle sustained when out_ready held high and DEPTH>=2.
- Backpressure: with out_ready=0, exactly DEPTH pushes accepted, then in_ready=0 until a pop.
- in_ready reacts to a pop one cycle later (registered-count decode).
- flush asserted at edge k: out_valid=0, in_ready=1, count=0 after edge k.
- All state updates on rising clk; rst_n asserts asynchronously, deasserts synchronously-safe (first push accepted on first edge with rst_n high).

## Test plan
- Reset: pulse rst_n low mid-cycle with count=2 -> count=0, out_valid=0, in_ready=1, out_mant=0, out_exp=0, out_flags=0 immediately, without clock edge.
- Streaming: DEPTH=2, out_ready=1, push mant 0x1000000..0x1000009 back-to-back -> outputs appear one cycle later, in order, one per cycle, count stays 1.
- Backpressure: out_ready=0, in_valid=1 for 4 cycles with exp 0x10,0x11,0x12,0x13 -> only 0x10,0x11 accepted, in_ready=0, count=2; release out_ready -> 0x10 then 0x11 popped, in_ready returns 1 one cycle after first pop.
- Full with simultaneous pop/push: count=DEPTH, out_ready=1, in_valid=1 -> pop only, count=DEPTH-1; next cycle push+pop -> count unchanged.
- Flush: DEPTH=4, 3 entries queued, flush=1 with in_valid=1 and out_ready=1 -> no push/pop, count=0, out_valid=0; next push of flags 0xA emerges first.
- Wrap-around: DEPTH=3, 20 pushes with random out_ready stalls, payload = index -> output sequence 0..19 intact, count never exceeds 3, no duplicates or drops.

Source files
------------

// File: rtl/fp_stage_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fp_stage_fifo
//  Description : Elastic DEPTH-entry stage buffer for the floating-point MAC
//                datapath. It carries the mantissa, exponent and flags of one
//                operation per entry over a valid/ready handshake. A
//                synchronous flush discards the buffered operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_stage_fifo #(
  parameter int MANT_W = 25,
  parameter int EXP_W  = 8,
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FLAG_W-1:0] out_flags,
  output logic [CNT_W-1:0]  count
);

  localparam int                 c_ent_w    = MANT_W + EXP_W + FLAG_W;
  localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   c_full_cnt = CNT_W'(DEPTH);

  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [c_ent_w-1:0] mem_q [DEPTH];
  logic [c_ent_w-1:0] head;
  logic               push;
  logic               pop;

  // Handshake flags decode only the registered occupancy, so in_ready never
  // depends combinationally on out_ready; a pop frees space one cycle later.
  assign in_ready  = (count_q != c_full_cnt);
  assign out_valid = (count_q != '0);

  // Flush wins over both transfers in the same cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Output fields come straight from the storage word at the read pointer.
  assign head                          = mem_q[rd_ptr_q];
  assign {out_mant, out_exp, out_flags} = head;
  assign count                         = count_q;

  // Next-state for pointers and occupancy; pointers wrap at DEPTH-1 so any
  // depth in the legal range works, not just powers of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Pointer and occupancy registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // One register per entry; reset clears the payload so the outputs read
  // zero straight out of reset, while flush leaves the contents stale.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    // Load this entry when the write pointer selects it during a push.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[e] <= '0;
      end else if (push && (wr_ptr_q == c_ptr_w'(e))) begin
        mem_q[e] <= {in_mant, in_exp, in_flags};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_stage_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_stage_fifo
//  Description : Scoreboard bench for fp_stage_fifo with three instances
//                (DEPTH 2, 3 and 4) driven by directed stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_stage_fifo;

  localparam int MW = 25;
  localparam int EW = 8;
  localparam int FW = 4;
  localparam int PW = MW + EW + FW;
  localparam int NI = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] in_valid;
  logic [NI-1:0] out_ready;
  logic [NI-1:0] flush;
  logic [MW-1:0] in_mant  [NI];
  logic [EW-1:0] in_exp   [NI];
  logic [FW-1:0] in_flags [NI];

  wire  [NI-1:0] in_ready_v;
  wire  [NI-1:0] out_valid_v;
  wire  [MW-1:0] out_mant_a  [NI];
  wire  [EW-1:0] out_exp_a   [NI];
  wire  [FW-1:0] out_flags_a [NI];
  wire  [3:0]    cnt_a       [NI];

  int errors = 0;
  int checks = 0;
  int pops [NI];

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D  = (g == 0) ? 2 : ((g == 1) ? 3 : 4);
    localparam int CW = $clog2(D + 1);

    logic [CW-1:0] cnt;
    logic [PW-1:0] q [$];
    bit            popm;
    bit            pushm;

    assign cnt_a[g] = 4'(cnt);

    fp_stage_fifo #(
      .MANT_W (MW),
      .EXP_W  (EW),
      .FLAG_W (FW),
      .DEPTH  (D)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready_v[g]),
      .in_mant   (in_mant[g]),
      .in_exp    (in_exp[g]),
      .in_flags  (in_flags[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready[g]),
      .out_mant  (out_mant_a[g]),
      .out_exp   (out_exp_a[g]),
      .out_flags (out_flags_a[g]),
      .count     (cnt)
    );

    // Reference queue: accepted payloads are pushed as stimulus is issued.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
      end else if (flush[g]) begin
        q.delete();
      end else begin
        popm  = (q.size() != 0) && out_ready[g];
        pushm = in_valid[g] && (q.size() != D);
        if (popm) void'(q.pop_front());
        if (pushm) q.push_back({in_mant[g], in_exp[g], in_flags[g]});
      end
    end

    // Monitor: occupancy/handshake flags every cycle, payload on each pop.
    always @(negedge clk) begin
      if (rst_n) begin
        chk($sformatf("count[%0d]", g), cnt, q.size());
        chk($sformatf("out_valid[%0d]", g), out_valid_v[g], q.size() != 0);
        chk($sformatf("in_ready[%0d]", g), in_ready_v[g], q.size() != D);
        if (out_valid_v[g] && out_ready[g] && !flush[g]) begin
          if (q.size() == 0) begin
            chk($sformatf("pop_on_empty[%0d]", g), 1, 0);
          end else begin
            chk($sformatf("payload[%0d]", g),
                {out_mant_a[g], out_exp_a[g], out_flags_a[g]}, q[0]);
            pops[g]++;
          end
        end
      end
    end

    // Reset must clear the visible state without waiting for a clock edge.
    always @(negedge rst_n) begin
      #1;
      chk($sformatf("rst_count[%0d]", g), cnt, 0);
      chk($sformatf("rst_valid[%0d]", g), out_valid_v[g], 0);
      chk($sformatf("rst_ready[%0d]", g), in_ready_v[g], 1);
      chk($sformatf("rst_payload[%0d]", g),
          {out_mant_a[g], out_exp_a[g], out_flags_a[g]}, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input int m, input int e, input int f);
    in_valid[i] = v;
    in_mant[i]  = MW'(m);
    in_exp[i]   = EW'(e);
    in_flags[i] = FW'(f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int guard;
    logic acc;
    for (int i = 0; i < NI; i++) begin
      drive(i, 1'b0, 0, 0, 0);
      out_ready[i] = 1'b0;
      flush[i]     = 1'b0;
      pops[i]      = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming on DEPTH=2: one push and one pop per cycle, count stays 1.
    out_ready[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, 32'h100_0000 + i, i, i);
      step();
      chk("stream_count", cnt_a[0], 1);
      chk("stream_mant", out_mant_a[0], 32'h100_0000 + i);
    end
    drive(0, 1'b0, 0, 0, 0);
    step();
    chk("stream_drained", cnt_a[0], 0);
    chk("stream_pops", pops[0], 10);

    // Backpressure: only two of four offered operations are accepted.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, i, 8'h10 + i, 0);
      step();
    end
    drive(0, 1'b0, 0, 0, 0);
    chk("bp_count", cnt_a[0], 2);
    chk("bp_in_ready", in_ready_v[0], 0);
    chk("bp_head_exp", out_exp_a[0], 8'h10);
    out_ready[0] = 1'b1;
    step();
    chk("bp_ready_back", in_ready_v[0], 1);
    chk("bp_second_exp", out_exp_a[0], 8'h11);
    step();
    chk("bp_empty", out_valid_v[0], 0);
    out_ready[0] = 1'b0;

    // Full with pop and push offered together: only the pop happens.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b1, 32'h20 + i, 0, 0);
      step();
    end
    chk("full_count", cnt_a[0], 2);
    out_ready[0] = 1'b1;
    drive(0, 1'b1, 32'h22, 0, 0);
    step();
    chk("full_pop_only", cnt_a[0], 1);
    drive(0, 1'b1, 32'h23, 0, 0);
    step();
    chk("full_push_pop", cnt_a[0], 1);
    chk("full_head", out_mant_a[0], 32'h23);
    drive(0, 1'b0, 0, 0, 0);
    step();
    chk("full_drained", cnt_a[0], 0);
    out_ready[0] = 1'b0;

    // Flush on DEPTH=4 with three entries queued and both transfers offered.
    for (int i = 0; i < 3; i++) begin
      drive(2, 1'b1, 32'h30 + i, 0, i + 1);
      step();
    end
    drive(2, 1'b0, 0, 0, 0);
    chk("fl_count", cnt_a[2], 3);
    flush[2] = 1'b1;
    out_ready[2] = 1'b1;
    drive(2, 1'b1, 32'h35, 0, 5);
    step();
    flush[2] = 1'b0;
    drive(2, 1'b0, 0, 0, 0);
    chk("fl_cleared", cnt_a[2], 0);
    chk("fl_valid", out_valid_v[2], 0);
    chk("fl_ready", in_ready_v[2], 1);
    drive(2, 1'b1, 32'h3A, 8'h3A, 4'hA);
    step();
    drive(2, 1'b0, 0, 0, 0);
    chk("fl_first_flags", out_flags_a[2], 4'hA);
    chk("fl_first_valid", out_valid_v[2], 1);
    step();
    chk("fl_drained", cnt_a[2], 0);
    out_ready[2] = 1'b0;

    // Wrap-around on DEPTH=3: 20 indexed payloads with random stalls.
    sent  = 0;
    guard = 0;
    while (sent < 20 && guard < 500) begin
      drive(1, 1'b1, sent, sent, sent);
      out_ready[1] = 1'($urandom_range(0, 1));
      acc = in_ready_v[1];
      step();
      if (acc) sent++;
      guard++;
    end
    chk("wrap_sent", sent, 20);
    drive(1, 1'b0, 0, 0, 0);
    out_ready[1] = 1'b1;
    repeat (4) step();
    chk("wrap_pops", pops[1], 20);
    chk("wrap_empty", cnt_a[1], 0);
    out_ready[1] = 1'b0;

    // Asynchronous reset mid-cycle while DEPTH=2 holds two entries.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b1, 32'h40 + i, 0, 0);
      step();
    end
    drive(0, 1'b0, 0, 0, 0);
    chk("pre_rst_count", cnt_a[0], 2);
    #2 rst_n = 1'b0;
    #2;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 1'b1, 32'h55, 8'h55, 4'h5);
    step();
    drive(0, 1'b0, 0, 0, 0);
    chk("post_rst_count", cnt_a[0], 1);
    chk("post_rst_mant", out_mant_a[0], 32'h55);
    out_ready[0] = 1'b1;
    step();
    chk("post_rst_empty", cnt_a[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
